// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//   Packet-granular round-robin arbiter. It merges NUM_INPUTS AXI-Stream
//   requesters into one AXI-Stream sink. Once a grant is issued it is held
//   from the first beat through the tlast beat, so packets never interleave.
//   After each packet the grant rotates, and the input just served drops to
//   lowest priority.
//
// Ports
//   clk            rising-edge clock
//   aresetn        asynchronous active-low reset, released synchronously
//   axis_i_tready  per-input ready (bit i -> input i)
//   axis_i_tvalid  per-input valid
//   axis_i_tlast   per-input end of packet
//   axis_i_tdata   concatenated input data, input i at [i*DW +: DW]
//   axis_o_tready  sink ready
//   axis_o_tvalid  sink valid
//   axis_o_tlast   sink end of packet
//   axis_o_tdata   sink data
//   grant_idx      index of the granted input (meaningful while busy=1)
//   busy           high while a packet grant is held
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int AXIS_BYTES = 1,
  localparam int SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int DW        = AXIS_BYTES * 8
) (
  input  logic                     clk,
  input  logic                     aresetn,
  output logic [NUM_INPUTS-1:0]    axis_i_tready,
  input  logic [NUM_INPUTS-1:0]    axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]    axis_i_tlast,
  input  logic [NUM_INPUTS*DW-1:0] axis_i_tdata,
  input  logic                     axis_o_tready,
  output logic                     axis_o_tvalid,
  output logic                     axis_o_tlast,
  output logic [DW-1:0]            axis_o_tdata,
  output logic [SEL_W-1:0]         grant_idx,
  output logic                     busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] last_grant;
  logic             sel_found;
  logic [SEL_W-1:0] sel_idx;
  logic [SEL_W-1:0] cand_sel;
  int               cand;
  logic             beat_acc;
  logic [DW-1:0]    in_data [NUM_INPUTS];

  // Unpack the data bus so the granted slice is a plain array lookup.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
    assign in_data[gi] = axis_i_tdata[gi*DW +: DW];
  end

  // Round-robin search starting just after the last served input. The
  // search ends on last_grant itself, so a lone requester always wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_sel  = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand     = (int'(last_grant) + k) % NUM_INPUTS;
      cand_sel = SEL_W'(cand);
      if (!sel_found && axis_i_tvalid[cand_sel]) begin
        sel_found = 1'b1;
        sel_idx   = cand_sel;
      end
    end
  end

  // In LOCKED the granted input is passed straight through. The output
  // valid depends only on the registered grant and the input valid, never
  // on axis_o_tready.
  always_comb begin
    axis_i_tready = '0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = '0;
    if (state == ST_LOCKED) begin
      axis_o_tvalid            = axis_i_tvalid[grant_idx];
      axis_o_tlast             = axis_i_tlast[grant_idx];
      axis_o_tdata             = in_data[grant_idx];
      axis_i_tready[grant_idx] = axis_o_tready;
    end
  end

  assign beat_acc = axis_o_tvalid && axis_o_tready;
  assign busy     = (state == ST_LOCKED);

  // Arbitration / grant hold register stage.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= SEL_W'(NUM_INPUTS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            state     <= ST_LOCKED;
          end
        end
        default: begin
          // A dropped input valid mid-packet keeps the lock; only an
          // accepted tlast beat releases it.
          if (beat_acc && axis_o_tlast) begin
            last_grant <= grant_idx;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
